// File: rtl/reshaper_wr_buffer_if.sv
// Memory-side write port of the reshaper write buffer.
// Ready/valid handshake carrying one {address, data} word per beat.
interface reshaper_wr_buffer_if #(
    parameter int AW = 16,
    parameter int DW = 512
);
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wvalid;
    logic          mem_wready;

    modport master (
        output mem_waddr,
        output mem_wdata,
        output mem_wvalid,
        input  mem_wready
    );

    modport slave (
        input  mem_waddr,
        input  mem_wdata,
        input  mem_wvalid,
        output mem_wready
    );
endinterface

// File: rtl/reshaper_wr_buffer.sv
// Write buffer between the reshaper and memory: FWFT FIFO of
// {addr, data} pairs plus a per-job IDLE/RUN/DRAIN/DONE controller.
module reshaper_wr_buffer #(
    parameter int AW    = 16,
    parameter int DW    = 512,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     init_pulse,
    input  logic [AW-1:0]            waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     wdata_vld,
    input  logic                     finish,
    reshaper_wr_buffer_if.master     mem,
    output logic [$clog2(DEPTH):0]   level,
    output logic [AW-1:0]            wr_cnt,
    output logic                     overflow,
    output logic                     done
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = AW + DW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic [AW-1:0]   wr_cnt_q;
    logic            overflow_q;
    logic            done_q;
    logic [EW-1:0]   fifo_q [DEPTH];
    logic [EW-1:0]   head;

    logic            active;
    logic            accept;
    logic            full;
    logic            not_empty;
    logic            push;
    logic            pop;
    logic            drop;

    assign active    = (state_q == RUN) || (state_q == DRAIN);
    assign accept    = wdata_vld && active && !init_pulse;
    assign full      = (level_q == LW'(DEPTH));
    assign not_empty = (level_q != '0);
    assign pop       = not_empty && mem.mem_wready;
    assign push      = accept && (!full || pop);
    assign drop      = accept && full && !pop;
    assign level_d   = level_q + LW'(push) - LW'(pop);

    // Storage is not reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {waddr, wdata};
        end
    end

    assign head           = fifo_q[rd_ptr_q];
    assign mem.mem_wvalid = not_empty;
    assign mem.mem_waddr  = not_empty ? head[EW-1:DW] : '0;
    assign mem.mem_wdata  = not_empty ? head[DW-1:0]  : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (init_pulse) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                wr_cnt_q <= wr_cnt_q + AW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            unique case (state_q)
                RUN: begin
                    if (finish) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!not_empty && !push) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign level    = level_q;
    assign wr_cnt   = wr_cnt_q;
    assign overflow = overflow_q;
    assign done     = done_q;
endmodule

// File: tb/tb_reshaper_wr_buffer.sv
// Directed bench for reshaper_wr_buffer with a scoreboard of
// expected memory writes checked on every accepted beat.
module tb_reshaper_wr_buffer;
    localparam int AW    = 16;
    localparam int DW    = 512;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset_n;
    logic          init_pulse;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wdata_vld;
    logic          finish;
    logic [LW-1:0] level;
    logic [AW-1:0] wr_cnt;
    logic          overflow;
    logic          done;

    reshaper_wr_buffer_if #(.AW(AW), .DW(DW)) mif ();

    reshaper_wr_buffer #(
        .AW(AW),
        .DW(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .init_pulse(init_pulse),
        .waddr(waddr),
        .wdata(wdata),
        .wdata_vld(wdata_vld),
        .finish(finish),
        .mem(mif),
        .level(level),
        .wr_cnt(wr_cnt),
        .overflow(overflow),
        .done(done)
    );

    int tests = 0;
    int fails = 0;
    logic [AW+DW-1:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkd(input logic [AW-1:0] a);
        return {16{16'hD00D, a}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic expect_acc);
        waddr     = a;
        wdata     = mkd(a);
        wdata_vld = 1'b1;
        if (expect_acc) sb.push_back({a, mkd(a)});
    endtask

    // Every accepted memory beat must match the oldest expected write.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (reset_n && !init_pulse && mif.mem_wvalid && mif.mem_wready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $error("FAIL pop_unexpected observed addr=%0h expected none",
                       mif.mem_waddr);
            end else begin
                e = sb.pop_front();
                assert ({mif.mem_waddr, mif.mem_wdata} === e) else begin
                    fails++;
                    $error("FAIL pop_data observed addr=%0h expected addr=%0h",
                           mif.mem_waddr, e[AW+DW-1:DW]);
                end
            end
        end
    end

    initial begin
        int mlvl;
        int maxlvl;
        logic rdy;

        reset_n        = 1'b0;
        init_pulse     = 1'b0;
        waddr          = '0;
        wdata          = '0;
        wdata_vld      = 1'b0;
        finish         = 1'b0;
        mif.mem_wready = 1'b0;
        tick();
        tick();
        chk("rst_level", 64'(level), 0);
        chk("rst_wr_cnt", 64'(wr_cnt), 0);
        chk("rst_overflow", 64'(overflow), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_wvalid", 64'(mif.mem_wvalid), 0);
        chk("rst_waddr", 64'(mif.mem_waddr), 0);
        chk("rst_wdata", 64'(|mif.mem_wdata), 0);
        reset_n = 1'b1;

        wr(16'h55, 1'b0);
        tick();
        wdata_vld = 1'b0;
        chk("idle_ignore_level", 64'(level), 0);
        chk("idle_ignore_ovf", 64'(overflow), 0);

        // Basic job
        mif.mem_wready = 1'b1;
        init_pulse = 1'b1;
        tick();
        init_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(AW'(i), 1'b1);
            finish = (i == 3);
            tick();
        end
        wdata_vld = 1'b0;
        finish    = 1'b0;
        chk("basic_done_c0", 64'(done), 0);
        tick();
        chk("basic_done_c1", 64'(done), 0);
        tick();
        chk("basic_done", 64'(done), 1);
        chk("basic_wr_cnt", 64'(wr_cnt), 4);
        chk("basic_sb_empty", 64'(sb.size()), 0);
        finish = 1'b1;
        wr(16'h77, 1'b0);
        tick();
        finish    = 1'b0;
        wdata_vld = 1'b0;
        chk("done_hold", 64'(done), 1);
        chk("done_ignore_wr", 64'(level), 0);

        // Backpressure and overflow
        mif.mem_wready = 1'b0;
        init_pulse = 1'b1;
        tick();
        init_pulse = 1'b0;
        chk("bp_init_done", 64'(done), 0);
        chk("bp_init_cnt", 64'(wr_cnt), 0);
        for (int i = 0; i < 8; i++) begin
            wr(AW'(16'h100 + i), 1'b1);
            tick();
        end
        wdata_vld = 1'b0;
        chk("bp_level8", 64'(level), 8);
        chk("bp_no_ovf", 64'(overflow), 0);
        chk("bp_head", 64'(mif.mem_waddr), 64'h100);
        wr(16'h1FF, 1'b0);
        tick();
        wdata_vld = 1'b0;
        chk("bp_ovf", 64'(overflow), 1);
        chk("bp_level_hold", 64'(level), 8);
        chk("bp_head_stable", 64'(mif.mem_waddr), 64'h100);
        mif.mem_wready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("bp_wr_cnt", 64'(wr_cnt), 8);
        chk("bp_drained", 64'(level), 0);
        chk("bp_ovf_sticky", 64'(overflow), 1);
        chk("bp_sb_empty", 64'(sb.size()), 0);

        // Full with simultaneous push and pop
        mif.mem_wready = 1'b0;
        init_pulse = 1'b1;
        tick();
        init_pulse = 1'b0;
        chk("fs_ovf_clr", 64'(overflow), 0);
        for (int i = 0; i < 8; i++) begin
            wr(AW'(16'h300 + i), 1'b1);
            tick();
        end
        wr(16'h3AA, 1'b1);
        mif.mem_wready = 1'b1;
        tick();
        wdata_vld = 1'b0;
        chk("fs_level8", 64'(level), 8);
        chk("fs_no_ovf", 64'(overflow), 0);
        chk("fs_wr_cnt", 64'(wr_cnt), 1);

        // Re-init while draining
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
        tick();
        mif.mem_wready = 1'b0;
        chk("ri_level5", 64'(level), 5);
        chk("ri_not_done", 64'(done), 0);
        init_pulse = 1'b1;
        sb.delete();
        tick();
        init_pulse = 1'b0;
        chk("ri_level0", 64'(level), 0);
        chk("ri_wvalid", 64'(mif.mem_wvalid), 0);
        chk("ri_done", 64'(done), 0);
        chk("ri_wr_cnt", 64'(wr_cnt), 0);
        wr(16'h400, 1'b1);
        tick();
        chk("ri_run_accepts", 64'(level), 1);

        // Reset mid-job
        wr(16'h401, 1'b1);
        tick();
        wr(16'h402, 1'b1);
        tick();
        wdata_vld = 1'b0;
        chk("mr_level3", 64'(level), 3);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        sb.delete();
        chk("mr_level", 64'(level), 0);
        chk("mr_wvalid", 64'(mif.mem_wvalid), 0);
        chk("mr_waddr", 64'(mif.mem_waddr), 0);
        chk("mr_wr_cnt", 64'(wr_cnt), 0);
        chk("mr_done", 64'(done), 0);
        wr(16'h4FF, 1'b0);
        tick();
        wdata_vld = 1'b0;
        chk("mr_ignore", 64'(level), 0);
        chk("mr_ignore_ovf", 64'(overflow), 0);

        // Wrap with random backpressure
        init_pulse = 1'b1;
        tick();
        init_pulse = 1'b0;
        mlvl   = 0;
        maxlvl = 0;
        for (int i = 0; i < 20; i++) begin
            rdy = 1'($urandom_range(0, 1));
            if (mlvl == DEPTH) rdy = 1'b1;
            mif.mem_wready = rdy;
            wr(AW'(16'h500 + i), 1'b1);
            tick();
            mlvl = mlvl + 1 - ((mlvl != 0 && rdy) ? 1 : 0);
            if (int'(level) > maxlvl) maxlvl = int'(level);
            chk("wrap_level", 64'(level), 64'(mlvl));
        end
        wdata_vld      = 1'b0;
        finish         = 1'b1;
        mif.mem_wready = 1'b1;
        tick();
        finish = 1'b0;
        for (int k = 0; k < 30 && !done; k++) tick();
        chk("wrap_done", 64'(done), 1);
        chk("wrap_wr_cnt", 64'(wr_cnt), 20);
        chk("wrap_max_level", 64'(maxlvl <= DEPTH), 1);
        chk("wrap_sb_empty", 64'(sb.size()), 0);
        chk("wrap_no_ovf", 64'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
